// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO controller: register offsets, reset values,
// warm-up length and the bus response state type.
package gpio_ctrl_pkg;

    // Byte offsets of the registers inside the window (bits [1:0] always 0).
    localparam logic [4:0] GPIO_IN       = 5'h00;
    localparam logic [4:0] GPIO_OUT      = 5'h04;
    localparam logic [4:0] GPIO_DIR      = 5'h08;
    localparam logic [4:0] GPIO_OUT_SET  = 5'h0C;
    localparam logic [4:0] GPIO_OUT_CLR  = 5'h10;
    localparam logic [4:0] GPIO_RISE_EN  = 5'h14;
    localparam logic [4:0] GPIO_FALL_EN  = 5'h18;
    localparam logic [4:0] GPIO_IRQ_STAT = 5'h1C;

    // Register reset values (truncated to NGPIO bits where used).
    localparam logic [31:0] RST_OUT      = 32'h0000_0000;
    localparam logic [31:0] RST_DIR      = 32'h0000_0000;
    localparam logic [31:0] RST_RISE_EN  = 32'h0000_0000;
    localparam logic [31:0] RST_FALL_EN  = 32'h0000_0000;
    localparam logic [31:0] RST_IRQ_STAT = 32'h0000_0000;

    // Edge detection stays off until the warm-up counter reaches this value,
    // so the synchronizer and previous-sample flops have filled with real pad
    // data before any edge can be reported.
    localparam logic [1:0] WARMUP_CYCLES = 2'd3;

    // Single-cycle bus response tracker.
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for asynchronous pad inputs, synchronous reset.
module gpio_sync #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_r [STAGES];

    // Shift the raw pad value through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: direction/output registers driving the pad
// bank, synchronized inputs with rise/fall edge capture into a W1C status
// register, and one level interrupt. Single-cycle bus with registered response.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int NGPIO       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_ack,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    input  logic [NGPIO-1:0]  i_gpio,
    output logic [NGPIO-1:0]  o_gpio,
    output logic [NGPIO-1:0]  en_gpio,
    output logic              o_irq
);

    localparam logic [NGPIO-1:0] ZERO_V = {NGPIO{1'b0}};
    localparam logic [NGPIO-1:0] ONES_V = {NGPIO{1'b1}};

    // Architectural state
    logic [NGPIO-1:0] out_r;
    logic [NGPIO-1:0] dir_r;
    logic [NGPIO-1:0] rise_en_r;
    logic [NGPIO-1:0] fall_en_r;
    logic [NGPIO-1:0] irq_stat_r;
    logic [NGPIO-1:0] en_gpio_r;
    logic [NGPIO-1:0] prev_r;
    logic [1:0]       warm_cnt_r;
    logic             irq_r;
    bus_state_e       bus_state_r;
    logic             err_r;
    logic [31:0]      rdata_r;

    // Combinational helpers
    logic [31:0]      addr_ext_s;
    logic [4:0]       reg_off_s;
    logic             mapped_s;
    logic             ro_hit_s;
    logic             bus_err_s;
    logic             wr_ok_s;
    logic [31:0]      rd_val_s;
    logic [NGPIO-1:0] wdata_s;
    logic [NGPIO-1:0] in_s;
    logic [NGPIO-1:0] out_nxt_s;
    logic [NGPIO-1:0] dir_nxt_s;
    logic [NGPIO-1:0] rise_en_nxt_s;
    logic [NGPIO-1:0] fall_en_nxt_s;
    logic [NGPIO-1:0] w1c_s;
    logic [NGPIO-1:0] rise_s;
    logic [NGPIO-1:0] fall_s;
    logic [NGPIO-1:0] irq_stat_nxt_s;
    logic             warm_done_s;
    bus_state_e       bus_state_nxt_s;
    logic             unused_s;

    assign addr_ext_s = 32'(i_addr);
    assign wdata_s    = i_wdata[NGPIO-1:0];
    // Address byte lanes and write-data bits above NGPIO carry no meaning.
    assign unused_s   = ^{addr_ext_s[1:0], i_wdata};

    gpio_sync #(
        .WIDTH  (NGPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_gpio),
        .q     (in_s)
    );

    // Address decode, read mux and error classification.
    always_comb begin
        reg_off_s = {addr_ext_s[4:2], 2'b00};
        mapped_s  = (addr_ext_s[31:5] == 27'd0);
        ro_hit_s  = 1'b0;
        rd_val_s  = 32'd0;
        case (reg_off_s)
            GPIO_IN: begin
                rd_val_s = 32'(in_s);
                ro_hit_s = 1'b1;
            end
            GPIO_OUT:      rd_val_s = 32'(out_r);
            GPIO_DIR:      rd_val_s = 32'(dir_r);
            GPIO_OUT_SET:  rd_val_s = 32'd0;
            GPIO_OUT_CLR:  rd_val_s = 32'd0;
            GPIO_RISE_EN:  rd_val_s = 32'(rise_en_r);
            GPIO_FALL_EN:  rd_val_s = 32'(fall_en_r);
            GPIO_IRQ_STAT: rd_val_s = 32'(irq_stat_r);
            default:       rd_val_s = 32'd0;
        endcase
        bus_err_s = i_stb && (!mapped_s || (i_we && ro_hit_s));
        wr_ok_s   = i_stb && i_we && !bus_err_s;
    end

    // Next register values from an accepted write.
    always_comb begin
        out_nxt_s     = out_r;
        dir_nxt_s     = dir_r;
        rise_en_nxt_s = rise_en_r;
        fall_en_nxt_s = fall_en_r;
        w1c_s         = ZERO_V;
        if (wr_ok_s) begin
            case (reg_off_s)
                GPIO_OUT:      out_nxt_s     = wdata_s;
                GPIO_DIR:      dir_nxt_s     = wdata_s;
                GPIO_OUT_SET:  out_nxt_s     = out_r | wdata_s;
                GPIO_OUT_CLR:  out_nxt_s     = out_r & ~wdata_s;
                GPIO_RISE_EN:  rise_en_nxt_s = wdata_s;
                GPIO_FALL_EN:  fall_en_nxt_s = wdata_s;
                GPIO_IRQ_STAT: w1c_s         = wdata_s;
                default:       w1c_s         = ZERO_V;
            endcase
        end else begin
            w1c_s = ZERO_V;
        end
    end

    // Edge detection gated by warm-up; a new edge beats a same-cycle clear.
    always_comb begin
        warm_done_s = (warm_cnt_r == WARMUP_CYCLES);
        if (warm_done_s) begin
            rise_s = in_s & ~prev_r;
            fall_s = ~in_s & prev_r;
        end else begin
            rise_s = ZERO_V;
            fall_s = ZERO_V;
        end
        irq_stat_nxt_s = (irq_stat_r & ~w1c_s)
                       | (rise_s & rise_en_r)
                       | (fall_s & fall_en_r);
    end

    // Bus response state: a strobe this cycle means an ack next cycle.
    always_comb begin
        bus_state_nxt_s = BUS_IDLE;
        case (i_stb)
            1'b1:    bus_state_nxt_s = BUS_RESP;
            1'b0:    bus_state_nxt_s = BUS_IDLE;
            default: bus_state_nxt_s = BUS_IDLE;
        endcase
    end

    // Bus response registers; read data is the pre-write register value.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_state_r <= BUS_IDLE;
            err_r       <= 1'b0;
            rdata_r     <= 32'd0;
        end else begin
            bus_state_r <= bus_state_nxt_s;
            err_r       <= bus_err_s;
            rdata_r     <= (i_stb && !i_we && !bus_err_s) ? rd_val_s : 32'd0;
        end
    end

    // Software-visible registers and pad drive; pads are inputs during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r      <= NGPIO'(RST_OUT);
            dir_r      <= NGPIO'(RST_DIR);
            rise_en_r  <= NGPIO'(RST_RISE_EN);
            fall_en_r  <= NGPIO'(RST_FALL_EN);
            irq_stat_r <= NGPIO'(RST_IRQ_STAT);
            en_gpio_r  <= ONES_V;
            irq_r      <= 1'b0;
        end else begin
            out_r      <= out_nxt_s;
            dir_r      <= dir_nxt_s;
            rise_en_r  <= rise_en_nxt_s;
            fall_en_r  <= fall_en_nxt_s;
            irq_stat_r <= irq_stat_nxt_s;
            en_gpio_r  <= ~dir_nxt_s;
            irq_r      <= |irq_stat_r;
        end
    end

    // Previous-sample flop and saturating warm-up counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r     <= ZERO_V;
            warm_cnt_r <= 2'd0;
        end else begin
            prev_r <= in_s;
            if (warm_cnt_r != WARMUP_CYCLES) begin
                warm_cnt_r <= warm_cnt_r + 2'd1;
            end else begin
                warm_cnt_r <= warm_cnt_r;
            end
        end
    end

    assign o_ack   = (bus_state_r == BUS_RESP);
    assign o_err   = err_r;
    assign o_rdata = rdata_r;
    assign o_gpio  = out_r;
    assign en_gpio = en_gpio_r;
    assign o_irq   = irq_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: bus vector tables plus hand sequences for
// edge timing, W1C-vs-edge, warm-up and back-to-back error responses.
module tb_gpio_ctrl;

    localparam int AW = 6;   // wide enough to address the unmapped 0x20

    localparam logic [AW-1:0] A_IN   = 6'h00;
    localparam logic [AW-1:0] A_OUT  = 6'h04;
    localparam logic [AW-1:0] A_DIR  = 6'h08;
    localparam logic [AW-1:0] A_SET  = 6'h0C;
    localparam logic [AW-1:0] A_CLR  = 6'h10;
    localparam logic [AW-1:0] A_REN  = 6'h14;
    localparam logic [AW-1:0] A_FEN  = 6'h18;
    localparam logic [AW-1:0] A_STAT = 6'h1C;
    localparam logic [AW-1:0] A_BAD  = 6'h20;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          exp_err;
        logic [31:0]   exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_stb = 1'b0;
    logic          i_we = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   i_wdata = 32'd0;
    logic          o_ack;
    logic          o_err;
    logic [31:0]   o_rdata;
    logic [23:0]   i_gpio = 24'h0;
    logic [23:0]   o_gpio;
    logic [23:0]   en_gpio;
    logic          o_irq;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t tbl[$];
    logic stb_d = 1'b0;

    gpio_ctrl #(.NGPIO(24), .SYNC_STAGES(2), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_stb   (i_stb),
        .i_we    (i_we),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .o_ack   (o_ack),
        .o_err   (o_err),
        .o_rdata (o_rdata),
        .i_gpio  (i_gpio),
        .o_gpio  (o_gpio),
        .en_gpio (en_gpio),
        .o_irq   (o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one bus transaction now and queue its expected response.
    task automatic drive(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
        exp_t e;
        i_stb   = 1'b1;
        i_we    = we;
        i_addr  = addr;
        i_wdata = wdata;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        sb.push_back(e);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        i_stb = 1'b0;
        i_we  = 1'b0;
    endtask

    task automatic add(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        tbl.push_back(v);
    endtask

    // Apply the vector table back-to-back, then drop the strobe.
    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rdata);
        end
        bus_idle();
        tbl.delete();
    endtask

    // Strobe accepted at this edge (outside reset) must be acked next cycle.
    always @(posedge clk) stb_d <= i_stb & ~reset;

    // Scoreboard: compare every ack against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (stb_d || o_ack) check("ack_timing", 32'(o_ack), 32'(stb_d));
        if (o_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_err", 32'(o_err), 32'(e.err));
                check("ack_rdata", o_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_en_gpio", 32'(en_gpio), 32'h00FF_FFFF);
        check("rst_o_gpio", 32'(o_gpio), 32'h0);
        check("rst_irq", 32'(o_irq), 32'h0);
        check("rst_ack", 32'(o_ack), 32'h0);
        reset = 1'b0;

        add(1'b0, A_IN,   32'h0, 1'b0, 32'h0);
        add(1'b0, A_OUT,  32'h0, 1'b0, 32'h0);
        add(1'b0, A_DIR,  32'h0, 1'b0, 32'h0);
        add(1'b0, A_SET,  32'h0, 1'b0, 32'h0);
        add(1'b0, A_CLR,  32'h0, 1'b0, 32'h0);
        add(1'b0, A_REN,  32'h0, 1'b0, 32'h0);
        add(1'b0, A_FEN,  32'h0, 1'b0, 32'h0);
        add(1'b0, A_STAT, 32'h0, 1'b0, 32'h0);
        // direction and set/clear
        add(1'b1, A_DIR,  32'h0000_000F, 1'b0, 32'h0);
        add(1'b1, A_OUT,  32'h0000_0005, 1'b0, 32'h0);
        add(1'b1, A_SET,  32'h0000_000A, 1'b0, 32'h0);
        add(1'b1, A_CLR,  32'h0000_0001, 1'b0, 32'h0);
        add(1'b0, A_OUT,  32'h0, 1'b0, 32'h0000_000E);
        add(1'b0, A_DIR,  32'h0, 1'b0, 32'h0000_000F);
        add(1'b1, A_OUT,  32'hFF00_000E, 1'b0, 32'h0);   // bits above NGPIO dropped
        add(1'b0, A_OUT,  32'h0, 1'b0, 32'h0000_000E);
        run_table();
        check("dir_o_gpio", 32'(o_gpio), 32'h0000_000E);
        check("dir_en_gpio", 32'(en_gpio), 32'h00FF_FFF0);

        // ---------------- input sync and edges ----------------
        i_gpio = 24'h000002;
        repeat (4) @(negedge clk);
        @(negedge clk); drive(1'b1, A_REN, 32'h1, 1'b0, 32'h0);
        @(negedge clk); drive(1'b1, A_FEN, 32'h2, 1'b0, 32'h0);
        @(negedge clk); drive(1'b0, A_STAT, 32'h0, 1'b0, 32'h0);
        @(negedge clk); i_gpio = 24'h000001; drive(1'b0, A_IN, 32'h0, 1'b0, 32'h2);
        @(negedge clk); drive(1'b0, A_IN, 32'h0, 1'b0, 32'h2);
        @(negedge clk); drive(1'b0, A_IN, 32'h0, 1'b0, 32'h1);
        check("edge_irq_early", 32'(o_irq), 32'h0);
        @(negedge clk); drive(1'b0, A_STAT, 32'h0, 1'b0, 32'h3);
        check("edge_irq_pre", 32'(o_irq), 32'h0);
        bus_idle();
        check("edge_irq_set", 32'(o_irq), 32'h1);

        // ---------------- W1C versus new edge ----------------
        i_gpio = 24'h000000;
        repeat (4) @(negedge clk);
        i_gpio = 24'h000001;
        @(negedge clk);
        @(negedge clk); drive(1'b1, A_STAT, 32'h3, 1'b0, 32'h0);
        @(negedge clk); drive(1'b0, A_STAT, 32'h0, 1'b0, 32'h1);
        check("w1c_irq_hold0", 32'(o_irq), 32'h1);
        @(negedge clk); drive(1'b1, A_STAT, 32'h1, 1'b0, 32'h0);
        check("w1c_irq_hold1", 32'(o_irq), 32'h1);
        @(negedge clk); drive(1'b0, A_STAT, 32'h0, 1'b0, 32'h0);
        check("w1c_irq_hold2", 32'(o_irq), 32'h1);
        bus_idle();
        check("w1c_irq_clear", 32'(o_irq), 32'h0);

        // ---------------- warm-up ----------------
        i_gpio = 24'hFFFFFF;
        @(negedge clk); drive(1'b1, A_REN, 32'h00FF_FFFF, 1'b0, 32'h0);
        bus_idle();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_en_gpio", 32'(en_gpio), 32'h00FF_FFFF);
        check("mid_rst_o_gpio", 32'(o_gpio), 32'h0);
        check("mid_rst_irq", 32'(o_irq), 32'h0);
        check("mid_rst_rdata", o_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, A_REN, 32'h00FF_FFFF, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(1'b0, A_STAT, 32'h0, 1'b0, 32'h0);
            check("warm_irq", 32'(o_irq), 32'h0);
        end
        bus_idle();
        check("warm_irq_end", 32'(o_irq), 32'h0);
        i_gpio = 24'hFFFFDF;
        repeat (5) @(negedge clk);
        i_gpio = 24'hFFFFFF;
        repeat (5) @(negedge clk);
        drive(1'b0, A_STAT, 32'h0, 1'b0, 32'h0000_0020);
        bus_idle();
        check("bit5_irq", 32'(o_irq), 32'h1);

        // ---------------- errors and throughput ----------------
        add(1'b1, A_IN,  32'hFFFF_FFFF, 1'b1, 32'h0);
        add(1'b0, A_BAD, 32'h0, 1'b1, 32'h0);
        add(1'b0, A_SET, 32'h0, 1'b0, 32'h0);
        add(1'b1, A_DIR, 32'h1, 1'b0, 32'h0);
        add(1'b0, A_DIR, 32'h0, 1'b0, 32'h1);
        add(1'b1, A_BAD, 32'h5, 1'b1, 32'h0);
        add(1'b0, A_IN,  32'h0, 1'b0, 32'h00FF_FFFF);
        run_table();
        check("err_en_gpio", 32'(en_gpio), 32'h00FF_FFFE);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
